// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int NIBBLE_W = 4;

  // Counter width for n steps; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_add.sv
// Per-cycle arithmetic slice: 4-bit a + b + cin -> {cout, sum}.
module nibble_add
  import serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_nibble_adder.sv
// Nibble-serial adder: W = 4*NIBBLES, LS nibble first, START/DONE handshake.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
//
// state   | meaning
// IDLE    | waiting for START
// ADD     | one nibble summed per cycle
// DONE    | result valid for one cycle; START here restarts immediately
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*NIBBLES-1:0]  A,
  input  logic [4*NIBBLES-1:0]  B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*NIBBLES-1:0]  SUM,
  output logic                  CARRY_OUT
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic                  OVF
`endif
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t              state, state_nx;
  logic                accept;
  logic [W-1:0]        a_sh, b_sh;
  logic [W-NIBBLE_W-1:0] res_sh;
  logic [W-1:0]        res_nx;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic [NIBBLE_W-1:0] s;
  logic                c;
  logic                last;
`ifdef SERIAL_ADDER_OVF_EN
  logic                sign_a, sign_b;
`endif

  nibble_add u_nibble_add (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (s),
    .cout (c)
  );

  // Newest nibble enters at the top so the LS nibble ends up at the bottom.
  assign res_nx = {s, res_sh};
  assign last   = (cnt == LAST);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          accept   = 1'b1;
          state_nx = ST_ADD;
        end
      end
      ST_ADD: begin
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (START) begin
          accept   = 1'b1;
          state_nx = ST_ADD;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      SUM       <= '0;
      CARRY_OUT <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      OVF       <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh  <= A;
        b_sh  <= B;
        carry <= 1'b0;
        cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
        sign_a <= A[W-1];
        sign_b <= B[W-1];
`endif
      end else if (state == ST_ADD) begin
        a_sh   <= a_sh >> NIBBLE_W;
        b_sh   <= b_sh >> NIBBLE_W;
        res_sh <= res_nx[W-1:NIBBLE_W];
        carry  <= c;
        cnt    <= cnt + CW'(1);
        if (last) begin
          SUM       <= res_nx;
          CARRY_OUT <= c;
`ifdef SERIAL_ADDER_OVF_EN
          OVF       <= (sign_a == sign_b) && (s[NIBBLE_W-1] != sign_a);
`endif
        end
      end
    end
  end

  assign BUSY = (state == ST_ADD);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench for serial_nibble_adder with NIBBLES=4.
module tb_serial_nibble_adder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] A, B;
  logic        BUSY, DONE, CARRY_OUT;
  logic [15:0] SUM;
`ifdef SERIAL_ADDER_OVF_EN
  logic        OVF;
`endif

  int errors = 0;
  int checks = 0;
  int n, busy_n, extra;

  serial_nibble_adder #(.NIBBLES(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .A         (A),
    .B         (B),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .SUM       (SUM),
    .CARRY_OUT (CARRY_OUT)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present START with operands and step past the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    START = 1'b1;
    A = a;
    B = b;
    tick();
    START = 1'b0;
  endtask

  // Bounded wait for DONE; counts edges taken and BUSY samples seen before it.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (DONE !== 1'b1 && cyc < 20) begin
      if (BUSY === 1'b1) busy_cyc++;
      tick();
      cyc++;
    end
  endtask

  // Count DONE pulses over a quiet window.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (DONE === 1'b1) pulses++;
    end
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    A = '0;
    B = '0;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_sum", SUM, 0);
    chk("rst_cout", CARRY_OUT, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", OVF, 0);
`endif
    RST = 1'b0;
    tick();
    chk("rst_start_ignored", BUSY, 0);

    // Basic add
    launch(16'h1234, 16'h4321);
    chk("basic_busy_now", BUSY, 1);
    chk("basic_sum_hold", SUM, 0);
    wait_done(n, busy_n);
    chk("basic_latency", n, 4);
    chk("basic_busy_cycles", busy_n, 4);
    chk("basic_sum", SUM, 16'h5555);
    chk("basic_cout", CARRY_OUT, 0);
    tick();
    chk("basic_done_pulse", DONE, 0);
    chk("basic_sum_held", SUM, 16'h5555);

    // Carry ripples through every nibble
    launch(16'hFFFF, 16'h0001);
    wait_done(n, busy_n);
    chk("ripple_latency", n, 4);
    chk("ripple_sum", SUM, 16'h0000);
    chk("ripple_cout", CARRY_OUT, 1);
    tick();

    // START during ADD ignored
    launch(16'h00FF, 16'h0001);
    tick();
    START = 1'b1;
    A = 16'hAAAA;
    B = 16'hAAAA;
    tick();
    START = 1'b0;
    wait_done(n, busy_n);
    chk("ign_latency", n, 2);
    chk("ign_sum", SUM, 16'h0100);
    chk("ign_cout", CARRY_OUT, 0);
    count_done(8, extra);
    chk("ign_extra_done", extra, 0);

    // Reset two cycles into ADD
    launch(16'h1234, 16'h4321);
    tick();
    tick();
    chk("mid_busy_before", BUSY, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_busy", BUSY, 0);
    chk("mid_sum", SUM, 0);
    chk("mid_done", DONE, 0);
    count_done(6, extra);
    chk("mid_no_done", extra, 0);
    launch(16'h0003, 16'h0004);
    wait_done(n, busy_n);
    chk("post_rst_sum", SUM, 16'h0007);

    // Back-to-back
    tick();
    launch(16'h8000, 16'h8000);
    wait_done(n, busy_n);
    chk("b2b1_sum", SUM, 16'h0000);
    chk("b2b1_cout", CARRY_OUT, 1);
    launch(16'h0001, 16'h0002);
    chk("b2b_busy", BUSY, 1);
    chk("b2b1_sum_hold", SUM, 16'h0000);
    wait_done(n, busy_n);
    chk("b2b_spacing", n + 1, 5);
    chk("b2b2_sum", SUM, 16'h0003);
    chk("b2b2_cout", CARRY_OUT, 0);
    tick();

    // Mixed nibbles with internal carries
    launch(16'hABCD, 16'h5678);
    wait_done(n, busy_n);
    chk("mix_sum", SUM, 16'h0245);
    chk("mix_cout", CARRY_OUT, 1);
    tick();

`ifdef SERIAL_ADDER_OVF_EN
    launch(16'h7FFF, 16'h0001);
    wait_done(n, busy_n);
    chk("ovf_sum", SUM, 16'h8000);
    chk("ovf_set", OVF, 1);
    tick();
    launch(16'hFFFF, 16'h0001);
    wait_done(n, busy_n);
    chk("ovf_clear", OVF, 0);
    tick();
    launch(16'h8000, 16'h8000);
    wait_done(n, busy_n);
    chk("ovf_neg", OVF, 1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
# serial_nibble_adder

Multi-word adder that sums two `NIBBLES`×4-bit operands one nibble per clock, least-significant nibble first. A carry flip-flop chains each nibble into the next. It sits directly downstream of the 4-bit half/nibble adder stage. It reuses that stage's 4-bit sum/carry arithmetic once per cycle to build wide results, so the full-width adder never has to be instantiated. Control is a START/DONE handshake with a BUSY status flag.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles; total width W = 4×NIBBLES; legal range 2..16.

Ports:
- `CLK`  input  1  single clock; all state updates on the rising edge.
- `RST`  input  1  reset, synchronous and active-high.
- `START`  input  1  request; sampled on a rising edge of `CLK`; accepted only in IDLE or DONE.
- `A`  input  W  operand A; captured on the accepting edge.
- `B`  input  W  operand B; captured on the accepting edge.
- `BUSY`  output  1  high while in ADD.
- `DONE`  output  1  one-cycle pulse; result valid.
- `SUM`  output  W  registered result, low W bits of A+B.
- `CARRY_OUT`  output  1  registered carry out of bit W-1.
- `OVF`  output  1  signed overflow; present only with `SERIAL_ADDER_OVF_EN` defined.

## Operation
- FSM has three states: IDLE, ADD and DONE.
- IDLE:
  - START=1 → capture A and B into internal shift registers.
  - Clear the carry flip-flop and the nibble counter.
  - Go to ADD.
- ADD: each cycle,
  - {c, s} = A_sh[3:0] + B_sh[3:0] + carry.
  - s is shifted into the top of the result shift register.
  - A_sh and B_sh shift right by 4.
  - carry ← c; counter increments.
  - When the counter reaches NIBBLES-1 → go to DONE, and load `SUM` ← final result register and `CARRY_OUT` ← c on that same edge.
- DONE:
  - `DONE`=1 for exactly one cycle.
  - START=1 → behaves as in IDLE (back-to-back operation); otherwise go to IDLE.
- Arithmetic is unsigned modulo 2^W; `CARRY_OUT` is bit W of A+B.
- START while in ADD is ignored. It is not queued, and A/B changes are also ignored.
- `SUM`/`CARRY_OUT`/`OVF` change only on the edge entering DONE. They hold until the next such edge.
- Reset values: state=IDLE, `BUSY`=0, `DONE`=0, `SUM`=0, `CARRY_OUT`=0, `OVF`=0, counter=0, carry=0.
- `RST` overrides everything, including mid-ADD: the partial result is discarded and `SUM` returns to 0.

## Timing
- START sampled at edge k → ADD from edge k+1 to edge k+NIBBLES.
- `BUSY`=1 for NIBBLES cycles.
- Result registers load at edge k+NIBBLES; `DONE`=1 for the cycle after that edge.
- Latency from START edge to `DONE` high = NIBBLES edges.
- Throughput: one operation every NIBBLES+1 cycles. Back-to-back: START asserted during the DONE cycle is accepted at the edge ending DONE.
- `RST` and START on the same edge: `RST` wins.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - The `OVF` port exists.
  - `OVF` = (A[W-1]==B[W-1]) && (SUM[W-1]!=A[W-1]), computed on the final nibble and registered with `SUM`.
  - Sign bits of A and B are retained at capture.
- `SERIAL_ADDER_OVF_EN` undefined: there is no `OVF` port and no sign-bit storage; all other behaviour is identical.

## Structure
- Shared package `serial_adder_pkg` holds:
  - the state enum (IDLE, ADD, DONE) with encoding 2'b00, 2'b01, 2'b10;
  - the constant NIBBLE_W = 4;
  - a counter-width function clog2(NIBBLES).
- One sub-module, `nibble_add`: combinational 4-bit a+b+cin → {cout, sum}, the per-cycle arithmetic slice. The FSM, shift registers and result registers live in the top.

## Test plan
All scenarios use NIBBLES=4.
- Basic add: reset, then START with A=16'h1234, B=16'h4321 → `BUSY` high 4 cycles; `DONE` pulse 4 edges after START; `SUM`=16'h5555, `CARRY_OUT`=0.
- Carry ripple across all nibbles: A=16'hFFFF, B=16'h0001 → `SUM`=16'h0000, `CARRY_OUT`=1.
- Ignored START: START with A=16'h00FF, B=16'h0001, then START pulsed again during ADD with A=B=16'hAAAA → `SUM`=16'h0100; exactly one `DONE` pulse.
- Reset mid-operation: RST asserted 2 cycles into ADD → next cycle `BUSY`=0, `SUM`=0, state IDLE; a following op A=16'h0003, B=16'h0004 → `SUM`=16'h0007.
- Back-to-back:
  - op1 A=16'h8000, B=16'h8000, with START held during the DONE cycle and A=16'h0001, B=16'h0002;
  - op1 result `SUM`=16'h0000, `CARRY_OUT`=1;
  - op2 `DONE` exactly 5 cycles after op1 `DONE`, `SUM`=16'h0003, `CARRY_OUT`=0.
- With `SERIAL_ADDER_OVF_EN` defined:
  - A=16'h7FFF, B=16'h0001 → `SUM`=16'h8000, `OVF`=1.
  - A=16'hFFFF, B=16'h0001 → `OVF`=0.
